// File: rtl/i2c_bit_master_pkg.sv
// Shared types and constants for the I2C byte-command bus engine.
package i2c_bit_master_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_STOP  = 2'b01,
    OP_WRITE = 2'b10,
    OP_READ  = 2'b11
  } op_t;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START_Q0 = 4'd1,
    ST_START_Q1 = 4'd2,
    ST_START_Q2 = 4'd3,
    ST_START_Q3 = 4'd4,
    ST_STOP_Q0  = 4'd5,
    ST_STOP_Q1  = 4'd6,
    ST_STOP_Q2  = 4'd7,
    ST_STOP_Q3  = 4'd8,
    ST_BIT_Q0   = 4'd9,
    ST_BIT_Q1   = 4'd10,
    ST_BIT_Q2   = 4'd11,
    ST_BIT_Q3   = 4'd12,
    ST_RESP     = 4'd13
  } state_t;

  // Eight data bits plus the acknowledge bit.
  localparam int BITS_PER_BYTE = 9;

endpackage

// File: rtl/i2c_bit_master_qtr_timer.sv
// Quarter-SCL-period prescaler; freeze_i holds the count while a slave stretches SCL,
// clear_i parks it at zero so every command starts on a full quarter.
module i2c_qtr_timer #(
  parameter int QTR_CYCLES = 250
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic freeze_i,
  output logic qtr_tick_o
);

  localparam int            CW   = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(QTR_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last  = (r_cnt == LAST);
  assign qtr_tick_o = w_at_last && !freeze_i && !clear_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_cnt <= '0;
    end else if (!freeze_i) begin
      r_cnt <= w_at_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_bit_master.sv
// I2C bus engine executing one START/STOP/WRITE/READ command at a time on open-drain SCL/SDA.
// Build option: define I2C_CLK_STRETCH_EN to let a slave stretch SCL (timer freezes while held low).
module i2c_bit_master
  import i2c_bit_master_pkg::*;
#(
  parameter int QTR_CYCLES = 250
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic [7:0] cmd_data_i,
  input  logic       cmd_ack_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_ack_o,
  output logic       rsp_err_o,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE - 1);

  state_t     r_state;
  op_t        r_op;
  logic [7:0] r_shift;
  logic [7:0] r_rx;
  logic [7:0] r_rsp_data;
  logic [3:0] r_bit;
  logic       r_held;
  logic       r_scl;
  logic       r_sda;
  logic       r_ready;
  logic       r_rsp_valid;
  logic       r_rsp_ack;
  logic       r_rsp_err;
  logic       r_err_pend;
  logic       r_ack_bit;
  logic       r_ack_smp;

  op_t  w_op;
  logic w_accept;
  logic w_illegal;
  logic w_arb_lost;
  logic w_tick;
  logic w_freeze;
  logic w_timer_clr;

  assign w_op        = op_t'(cmd_op_i);
  assign w_accept    = cmd_valid_i && r_ready;
  assign w_illegal   = (w_op != OP_START) && !r_held;
  assign w_arb_lost  = (r_op == OP_WRITE) && (r_bit != LAST_BIT) && r_sda && !sda_i;
  assign w_timer_clr = (r_state == ST_IDLE);

`ifdef I2C_CLK_STRETCH_EN
  assign w_freeze = ((r_state == ST_BIT_Q1) || (r_state == ST_BIT_Q2) ||
                     (r_state == ST_START_Q1)) && r_scl && !scl_i;
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_i;
  assign w_freeze     = 1'b0;
`endif

  i2c_qtr_timer #(
    .QTR_CYCLES (QTR_CYCLES)
  ) u_qtr_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (w_timer_clr),
    .freeze_i   (w_freeze),
    .qtr_tick_o (w_tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_START;
      r_shift     <= '0;
      r_rx        <= '0;
      r_rsp_data  <= '0;
      r_bit       <= '0;
      r_held      <= 1'b0;
      r_scl       <= 1'b1;
      r_sda       <= 1'b1;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_ack   <= 1'b1;
      r_rsp_err   <= 1'b0;
      r_err_pend  <= 1'b0;
      r_ack_bit   <= 1'b1;
      r_ack_smp   <= 1'b1;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_ready    <= 1'b0;
          r_op       <= w_op;
          r_shift    <= cmd_data_i;
          r_ack_bit  <= cmd_ack_i;
          r_bit      <= '0;
          r_err_pend <= w_illegal;
          if (w_illegal) begin
            r_state <= ST_RESP;
          end else if (w_op == OP_START) begin
            // Repeated start keeps SCL low while SDA is let go.
            r_state <= ST_START_Q0;
            r_scl   <= !r_held;
            r_sda   <= 1'b1;
          end else if (w_op == OP_STOP) begin
            r_state <= ST_STOP_Q0;
            r_sda   <= 1'b0;
          end else begin
            r_state <= ST_BIT_Q0;
            r_sda   <= (w_op == OP_READ) || cmd_data_i[7];
          end
        end
        ST_START_Q0: if (w_tick) begin r_state <= ST_START_Q1; r_scl <= 1'b1; end
        ST_START_Q1: if (w_tick) begin r_state <= ST_START_Q2; r_sda <= 1'b0; end
        ST_START_Q2: if (w_tick) begin r_state <= ST_START_Q3; r_scl <= 1'b0; end
        ST_START_Q3: if (w_tick) begin r_state <= ST_RESP;     r_held <= 1'b1; end
        ST_STOP_Q0:  if (w_tick) begin r_state <= ST_STOP_Q1;  r_scl <= 1'b1; end
        ST_STOP_Q1:  if (w_tick) begin r_state <= ST_STOP_Q2;  r_sda <= 1'b1; end
        ST_STOP_Q2:  if (w_tick) begin r_state <= ST_STOP_Q3; end
        ST_STOP_Q3:  if (w_tick) begin r_state <= ST_RESP;     r_held <= 1'b0; end
        ST_BIT_Q0:   if (w_tick) begin r_state <= ST_BIT_Q1;   r_scl <= 1'b1; end
        ST_BIT_Q1: if (w_tick) begin
          if (w_arb_lost) begin
            r_scl      <= 1'b1;
            r_sda      <= 1'b1;
            r_held     <= 1'b0;
            r_err_pend <= 1'b1;
            r_state    <= ST_RESP;
          end else begin
            r_state <= ST_BIT_Q2;
            if (r_bit == LAST_BIT) r_ack_smp <= sda_i;
            else                   r_rx      <= {r_rx[6:0], sda_i};
          end
        end
        ST_BIT_Q2: if (w_tick) begin r_state <= ST_BIT_Q3; r_scl <= 1'b0; end
        ST_BIT_Q3: if (w_tick) begin
          if (r_bit == LAST_BIT) begin
            r_state <= ST_RESP;
          end else begin
            r_state <= ST_BIT_Q0;
            r_bit   <= r_bit + 4'd1;
            r_shift <= {r_shift[6:0], 1'b0};
            // Next pass is the acknowledge bit: release for WRITE, drive our ack for READ.
            if (r_bit == LAST_BIT - 4'd1) r_sda <= (r_op == OP_WRITE) ? 1'b1 : r_ack_bit;
            else                          r_sda <= (r_op == OP_READ) || r_shift[6];
          end
        end
        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= r_err_pend;
          if (!r_err_pend && (r_op == OP_READ))  r_rsp_data <= r_rx;
          if (!r_err_pend && (r_op == OP_WRITE)) r_rsp_ack  <= r_ack_smp;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = r_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_ack_o   = r_rsp_ack;
  assign rsp_err_o   = r_rsp_err;
  assign scl_o       = r_scl;
  assign sda_o       = r_sda;

endmodule

// File: tb/tb_i2c_bit_master.sv
// Directed bench for i2c_bit_master with a small behavioural I2C slave at address 0x44.
`timescale 1ns/1ps
module tb_i2c_bit_master;

  localparam int Q = 250;
`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_LAT = 36 * Q + 1 + 300;
`else
  localparam int STRETCH_LAT = 36 * Q + 1;
`endif

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic [1:0] cmd_op_i = 2'b00;
  logic [7:0] cmd_data_i = 8'h00;
  logic       cmd_ack_i = 1'b0;
  logic       cmd_ready_o, rsp_valid_o, rsp_ack_o, rsp_err_o, scl_o, sda_o, scl_i, sda_i;
  logic [7:0] rsp_data_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  i2c_bit_master #(.QTR_CYCLES(Q)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_data_i  (cmd_data_i),
    .cmd_ack_i   (cmd_ack_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_ack_o   (rsp_ack_o),
    .rsp_err_o   (rsp_err_o),
    .scl_o       (scl_o),
    .sda_o       (sda_o),
    .scl_i       (scl_i),
    .sda_i       (sda_i)
  );

  // Open-drain bus with a slave model and an arbitration-fault injector.
  logic       s_scl = 1'b1, s_sda = 1'b1, s_force = 1'b0;
  int         s_bitcnt = 0, s_byte = 0, start_cnt = 0, stop_cnt = 0;
  logic [7:0] s_shift = 8'h00, s_addr_byte = 8'h00, s_tx = 8'h5A;
  logic       s_rd = 1'b0, s_mack = 1'b0;

  assign scl_i = scl_o & s_scl;
  assign sda_i = sda_o & s_sda & ~s_force;

  always @(negedge sda_i) if (scl_i === 1'b1) begin
    start_cnt++; s_bitcnt = 0; s_byte = 0; s_rd = 1'b0; s_sda = 1'b1;
  end
  always @(posedge sda_i) if (scl_i === 1'b1) stop_cnt++;

  always @(posedge scl_i) begin
    if (s_bitcnt < 8) s_shift = {s_shift[6:0], sda_i};
    else              s_mack  = sda_i;
    s_bitcnt++;
    if (s_bitcnt == 8 && s_byte == 0) begin
      s_addr_byte = s_shift;
      s_rd        = s_shift[0] && (s_shift[7:1] == 7'h44);
    end
  end

  always @(negedge scl_i) begin
    s_sda = 1'b1;
    if (s_bitcnt == 9) begin
      if (s_byte > 0 && s_rd && s_mack) s_rd = 1'b0;
      s_bitcnt = 0;
      s_byte++;
    end
    if (s_bitcnt == 8 && (s_byte == 0 ? (s_addr_byte[7:1] == 7'h44) : !s_rd)) s_sda = 1'b0;
    else if (s_bitcnt < 8 && s_byte > 0 && s_rd) s_sda = s_tx[7 - s_bitcnt];
  end

  int cyc = 0, t_rise_prev = 0, t_rise_last = 0;
  always @(posedge clk) cyc++;
  always @(posedge scl_o) begin t_rise_prev = t_rise_last; t_rise_last = cyc; end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] data, input logic ack, output int lat);
    @(negedge clk);
    check("ready_before_cmd", cmd_ready_o, 1'b1);
    cmd_op_i = op; cmd_data_i = data; cmd_ack_i = ack; cmd_valid_i = 1'b1;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    check("ready_drop_after_accept", cmd_ready_o, 1'b0);
    lat = 0;
    while (lat < 20000) begin
      @(posedge clk);
      lat++;
      #1;
      if (rsp_valid_o) break;
    end
    check("ready_with_rsp", cmd_ready_o, 1'b1);
    $display("cmd op=%0d data=%02h ack_in=%0b -> lat=%0d err=%0b rsp_ack=%0b rsp_data=%02h",
             op, data, ack, lat, rsp_err_o, rsp_ack_o, rsp_data_o);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; cmd_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", scl_o, 1'b1);
    check("rst_sda", sda_o, 1'b1);
    check("rst_ready", cmd_ready_o, 1'b1);
    check("rst_valid", rsp_valid_o, 1'b0);
    check("rst_data", rsp_data_o, 8'h00);
    check("rst_ack", rsp_ack_o, 1'b1);
    check("rst_err", rsp_err_o, 1'b0);
    rst_i = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   lat, seen, guard, start_save, valid_seen;
    logic prev;

    // Reset, then a plain START.
    do_reset();
    start_cnt = 0; stop_cnt = 0;
    do_cmd(2'b00, 8'h00, 1'b0, lat);
    check("start_latency", lat, 4 * Q + 1);
    check("start_err", rsp_err_o, 1'b0);
    check("start_seen_on_bus", start_cnt, 1);
    check("start_scl_low", scl_o, 1'b0);
    check("start_sda_low", sda_o, 1'b0);

    // Address byte 0x88 -> slave 0x44, write.
    do_cmd(2'b10, 8'h88, 1'b0, lat);
    check("write_latency", lat, 36 * Q + 1);
    check("write_err", rsp_err_o, 1'b0);
    check("write_ack", rsp_ack_o, 1'b0);
    check("scl_period", t_rise_last - t_rise_prev, 4 * Q);
    check("slave_addr_byte", s_addr_byte, 8'h88);

    // Repeated START, read address, READ with NAK, STOP.
    do_cmd(2'b00, 8'h00, 1'b0, lat);
    check("rstart_latency", lat, 4 * Q + 1);
    check("rstart_seen", start_cnt, 2);
    do_cmd(2'b10, 8'h89, 1'b0, lat);
    check("rd_addr_ack", rsp_ack_o, 1'b0);
    check("rd_addr_err", rsp_err_o, 1'b0);
    do_cmd(2'b11, 8'h00, 1'b1, lat);
    check("read_latency", lat, 36 * Q + 1);
    check("read_data", rsp_data_o, 8'h5A);
    check("read_err", rsp_err_o, 1'b0);
    check("read_keeps_write_ack", rsp_ack_o, 1'b0);
    check("read_nak_on_bus", s_mack, 1'b1);
    do_cmd(2'b01, 8'h00, 1'b0, lat);
    check("stop_latency", lat, 4 * Q + 1);
    check("stop_err", rsp_err_o, 1'b0);
    check("stop_seen", stop_cnt, 1);
    check("stop_keeps_data", rsp_data_o, 8'h5A);
    check("stop_scl_rel", scl_o, 1'b1);
    check("stop_sda_rel", sda_o, 1'b1);

    // STOP with no bus owned is illegal.
    do_reset();
    start_save = start_cnt;
    do_cmd(2'b01, 8'h00, 1'b0, lat);
    check("illegal_latency", lat, 1);
    check("illegal_err", rsp_err_o, 1'b1);
    check("illegal_scl", scl_o, 1'b1);
    check("illegal_sda", sda_o, 1'b1);
    @(posedge clk); #1;
    check("illegal_valid_one_cycle", rsp_valid_o, 1'b0);
    check("illegal_no_bus_start", start_cnt, start_save);

    // Arbitration loss on the MSB of WRITE 0xFF.
    do_cmd(2'b00, 8'h00, 1'b0, lat);
    check("arb_start_latency", lat, 4 * Q + 1);
    s_force = 1'b1;
    do_cmd(2'b10, 8'hFF, 1'b0, lat);
    check("arb_latency", lat, 2 * Q + 1);
    check("arb_err", rsp_err_o, 1'b1);
    check("arb_scl_rel", scl_o, 1'b1);
    check("arb_sda_rel", sda_o, 1'b1);
    s_force = 1'b0;
    do_cmd(2'b10, 8'h00, 1'b0, lat);
    check("post_arb_write_latency", lat, 1);
    check("post_arb_write_err", rsp_err_o, 1'b1);

    // Slave holds SCL low 300 clocks at the start of bit 3.
    do_cmd(2'b00, 8'h00, 1'b0, lat);
    seen = 0; guard = 0; prev = scl_o;
    fork
      do_cmd(2'b10, 8'h88, 1'b0, lat);
      begin
        while (seen < 2 && guard < 20000) begin
          @(posedge clk); #1; guard++;
          if (scl_o && !prev) seen++;
          prev = scl_o;
        end
        while (scl_o && guard < 20000) begin @(posedge clk); #1; guard++; end
        s_scl = 1'b0;
        while (!scl_o && guard < 20000) begin @(posedge clk); #1; guard++; end
        repeat (300) @(posedge clk);
        #1 s_scl = 1'b1;
      end
    join
    check("stretch_wait_bound", guard < 20000, 1'b1);
    check("stretch_latency", lat, STRETCH_LAT);
    check("stretch_ack", rsp_ack_o, 1'b0);
    do_cmd(2'b01, 8'h00, 1'b0, lat);
    check("stretch_stop_err", rsp_err_o, 1'b0);

    // Reset in the middle of a START: lines released, no response.
    @(negedge clk);
    cmd_op_i = 2'b00; cmd_valid_i = 1'b1;
    @(posedge clk); #1 cmd_valid_i = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    check("mid_start_sda_low", sda_o, 1'b0);
    rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    check("mid_rst_scl", scl_o, 1'b1);
    check("mid_rst_sda", sda_o, 1'b1);
    valid_seen = 0;
    repeat (1200) begin
      @(posedge clk); #1;
      if (rsp_valid_o) valid_seen++;
    end
    check("mid_rst_no_rsp", valid_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
